// File: rtl/wb_ctrl.sv
// Write-back controller: drives the regfile write port, diverts r15 writes to the PC,
// blocks on loads and tracks outstanding destinations.
module wb_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        ex_wen,
    input  logic        ex_is_load,
    input  logic        ex_ld_byte,
    input  logic [1:0]  ex_addr_lo,
    input  logic [3:0]  ex_rd,
    input  logic [31:0] ex_result,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        we3,
    output logic [3:0]  wa3,
    output logic [31:0] wd3,
    output logic        pc_we,
    output logic [31:0] pc_wd,
    output logic [15:0] pending,
    output logic        err_timeout,
    output logic        err_spurious
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [3:0]    ld_rd;
    logic          ld_byte;
    logic [1:0]    ld_addr;

    logic [31:0]   ld_data;
    logic          wr_en;
    logic [3:0]    wr_rd;
    logic [31:0]   wr_data;
    logic          accept;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;

    always_comb begin
        ld_data = mem_rdata;
        if (ld_byte)
            ld_data = {24'b0, mem_rdata[{ld_addr, 3'b000} +: 8]};
    end

    // One write source per cycle: the accepted ALU op in IDLE, the load return otherwise.
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = ex_rd;
        wr_data = ex_result;
        if (state == IDLE) begin
            wr_en = accept && ex_wen && !ex_is_load;
        end else begin
            wr_en   = mem_rvalid;
            wr_rd   = ld_rd;
            wr_data = ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            ld_rd        <= '0;
            ld_byte      <= 1'b0;
            ld_addr      <= '0;
            we3          <= 1'b0;
            wa3          <= '0;
            wd3          <= '0;
            pc_we        <= 1'b0;
            pc_wd        <= '0;
            pending      <= '0;
            err_timeout  <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            we3   <= wr_en && (wr_rd != 4'd15);
            pc_we <= wr_en && (wr_rd == 4'd15);
            if (wr_en && (wr_rd != 4'd15)) begin
                wa3 <= wr_rd;
                wd3 <= wr_data;
            end
            if (wr_en && (wr_rd == 4'd15))
                pc_wd <= wr_data;

            case (state)
                IDLE: begin
                    if (mem_rvalid)
                        err_spurious <= 1'b1;
                    if (accept && ex_wen && ex_is_load) begin
                        ld_rd          <= ex_rd;
                        ld_byte        <= ex_ld_byte;
                        ld_addr        <= ex_addr_lo;
                        pending[ex_rd] <= 1'b1;
                        cnt            <= '0;
                        state          <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid) begin
                        pending[ld_rd] <= 1'b0;
                        state          <= IDLE;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        err_timeout    <= 1'b1;
                        pending[ld_rd] <= 1'b0;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
